// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: FSM states, ALU op classes,
// M-extension funct3 codes and forwarding-select encodings.
package exec_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [2:0] F3_MUL   = 3'b000;
  localparam logic [2:0] F3_MULHU = 3'b011;
  localparam logic [2:0] F3_DIV   = 3'b100;
  localparam logic [2:0] F3_DIVU  = 3'b101;
  localparam logic [2:0] F3_REM   = 3'b110;
  localparam logic [2:0] F3_REMU  = 3'b111;

  localparam logic [1:0] FWD_EM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b01;

  function automatic logic md_supported(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULHU) || f3[2];
  endfunction

  function automatic logic md_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing one
// 2*XLEN accumulator; XLEN iterations, then one cycle of sign fix-up.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);

  logic              running, fin, is_div, hi_sel, neg_q, neg_r, div0;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, mul_next, div_next;
  logic [XLEN-1:0]   opb, dividend, mag_a, mag_b, quo, rem, diff, result;
  logic [XLEN:0]     mul_sum;
  logic              sgn, sa, sb, ge;

  // Only signed DIV/REM take magnitudes; MUL low half is sign-agnostic.
  assign sgn   = md_is_div(funct3) && !funct3[0];
  assign sa    = sgn && a[XLEN-1];
  assign sb    = sgn && b[XLEN-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  assign quo = acc[XLEN-1:0];
  assign rem = acc[2*XLEN-1:XLEN];

  assign mul_sum  = {1'b0, rem} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Partial remainder shifted left with the next dividend bit appended.
  assign ge       = acc[2*XLEN-1:XLEN-1] >= {1'b0, opb};
  assign diff     = acc[2*XLEN-2:XLEN-1] - opb;
  assign div_next = {ge ? diff : acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], ge};

  assign last = running && (cnt == CW'(XLEN-1));

  always_comb begin
    result = '0;
    if (!is_div)     result = hi_sel ? rem : quo;
    else if (div0)   result = hi_sel ? dividend : '1;
    else if (hi_sel) result = neg_r ? -rem : rem;
    else             result = neg_q ? -quo : quo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      running  <= 1'b0;
      fin      <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      dividend <= '0;
      res      <= '0;
      is_div   <= 1'b0;
      hi_sel   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
    end else begin
      fin  <= 1'b0;
      done <= 1'b0;
      if (start) begin
        running  <= 1'b1;
        cnt      <= '0;
        acc      <= {{XLEN{1'b0}}, mag_a};
        opb      <= mag_b;
        dividend <= a;
        is_div   <= md_is_div(funct3);
        hi_sel   <= funct3[1];
        neg_q    <= sa ^ sb;
        neg_r    <= sa;
        div0     <= (b == '0);
      end else if (running) begin
        acc <= is_div ? div_next : mul_next;
        cnt <= cnt + 1'b1;
        if (last) begin
          running <= 1'b0;
          fin     <= 1'b1;
        end
      end else if (fin) begin
        res  <= result;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/execute_multicycle.sv
// Execute stage: forwarding, single-cycle ALU and an optional iterative
// mul/div unit behind a valid/ready handshake with registered outputs.
module execute_multicycle
  import exec_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int MULDIV_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] em_alu_res,
  input  logic [XLEN-1:0] wb_rd_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_res,
  output logic            zero,
  output logic            ov,
  output logic [XLEN-1:0] pc_off,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);

  logic [1:0]      state;
  logic [XLEN-1:0] opa, opb_fwd, opb, add_res, sub_res, plain_res, pc_off_c, pc_pend;
  logic [XLEN-1:0] md_res;
  logic [SW-1:0]   shamt;
  logic            is_mop, md_go, accept, is_add, is_sub, plain_ov, md_last, md_done;

  always_comb begin
    case (forward_a)
      FWD_EM:  opa = em_alu_res;
      FWD_WB:  opa = wb_rd_out;
      default: opa = rd1;
    endcase
    case (forward_b)
      FWD_EM:  opb_fwd = em_alu_res;
      FWD_WB:  opb_fwd = wb_rd_out;
      default: opb_fwd = rd2;
    endcase
  end

  assign opb      = alu_src ? imm : opb_fwd;
  assign shamt    = opb[SW-1:0];
  assign add_res  = opa + opb;
  assign sub_res  = opa - opb;
  assign pc_off_c = pc_in + (imm << 1);

  assign is_mop   = (MULDIV_EN != 0) && (alu_op == ALU_FUNCT) && funct7_0;
  assign md_go    = is_mop && md_supported(funct3);
  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign busy     = (state != S_IDLE);

  // Unsupported M-op encodings fall through with plain_res left at zero.
  always_comb begin
    plain_res = '0;
    plain_ov  = 1'b0;
    is_add    = 1'b0;
    is_sub    = 1'b0;
    case (alu_op)
      ALU_ADD: is_add = 1'b1;
      ALU_SUB: is_sub = 1'b1;
      ALU_FUNCT: if (!is_mop) begin
        case (funct3)
          3'b000: begin
            is_sub = funct7_5 && !alu_src;
            is_add = !(funct7_5 && !alu_src);
          end
          3'b001: plain_res = opa << shamt;
          3'b010: plain_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
          3'b011: plain_res = {{(XLEN-1){1'b0}}, opa < opb};
          3'b100: plain_res = opa ^ opb;
          3'b101: plain_res = funct7_5 ? XLEN'($signed(opa) >>> shamt) : opa >> shamt;
          3'b110: plain_res = opa | opb;
          default: plain_res = opa & opb;
        endcase
      end
      default: plain_res = opb;
    endcase
    if (is_add) begin
      plain_res = add_res;
      plain_ov  = (opa[XLEN-1] == opb[XLEN-1]) && (add_res[XLEN-1] != opa[XLEN-1]);
    end
    if (is_sub) begin
      plain_res = sub_res;
      plain_ov  = (opa[XLEN-1] != opb[XLEN-1]) && (sub_res[XLEN-1] != opa[XLEN-1]);
    end
  end

  generate
    if (MULDIV_EN != 0) begin : g_md
      muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk    (clk),
        .rst_n  (rst_n),
        .abort  (flush),
        .start  (accept && md_go),
        .funct3 (funct3),
        .a      (opa),
        .b      (opb),
        .last   (md_last),
        .done   (md_done),
        .res    (md_res)
      );
    end else begin : g_no_md
      assign md_last = 1'b0;
      assign md_done = 1'b0;
      assign md_res  = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      alu_res   <= '0;
      zero      <= 1'b1;
      ov        <= 1'b0;
      pc_off    <= '0;
      pc_pend   <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && md_go) begin
            state     <= md_is_div(funct3) ? S_DIV : S_MUL;
            pc_pend   <= pc_off_c;
            out_valid <= 1'b0;
          end else if (accept) begin
            alu_res   <= plain_res;
            zero      <= (plain_res == '0);
            ov        <= plain_ov;
            pc_off    <= pc_off_c;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        S_MUL, S_DIV: if (md_last) state <= S_DONE;
        // DONE spans the unit's fix-up cycle and the result-register load.
        S_DONE: if (md_done) begin
          state     <= S_IDLE;
          alu_res   <= md_res;
          zero      <= (md_res == '0);
          ov        <= 1'b0;
          pc_off    <= pc_pend;
          out_valid <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_multicycle.sv
// Directed bench for execute_multicycle (XLEN=64): ALU, forwarding, mul/div,
// latency, flush, backpressure and reset.
module tb_execute_multicycle;

  localparam int XLEN = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, flush, alu_src, funct7_5, funct7_0;
  logic [XLEN-1:0] pc_in, rd1, rd2, imm, em_alu_res, wb_rd_out, alu_res, pc_off;
  logic [1:0]      alu_op, forward_a, forward_b;
  logic [2:0]      funct3;
  logic            out_valid, out_ready, zero, ov, busy;

  int total = 0;
  int passed = 0;

  execute_multicycle #(.XLEN(XLEN), .MULDIV_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .pc_in(pc_in), .rd1(rd1), .rd2(rd2), .imm(imm), .alu_src(alu_src), .alu_op(alu_op),
    .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0), .forward_a(forward_a),
    .forward_b(forward_b), .em_alu_res(em_alu_res), .wb_rd_out(wb_rd_out),
    .out_valid(out_valid), .out_ready(out_ready), .alu_res(alu_res), .zero(zero),
    .ov(ov), .pc_off(pc_off), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                       input logic f70, input logic src, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] im);
    alu_op = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70; alu_src = src;
    rd1 = a; rd2 = b; imm = im; in_valid = 1'b1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                       input logic f70, input logic src, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] im);
    drive(op, f3, f75, f70, src, a, b, im);
    tick();
    in_valid = 1'b0;
  endtask

  // Issues an M-op and waits for its result; lat counts edges after acceptance.
  task automatic md_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat, output bit rdy_seen);
    issue(2'b10, f3, 1'b0, 1'b1, 1'b0, a, b, 64'd8);
    funct7_0 = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    res = alu_res;
  endtask

  logic [63:0] r;
  int          lat;
  bit          rdy, seen;
  logic [63:0] held_res, held_pc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    pc_in = 64'h100; rd1 = '0; rd2 = '0; imm = '0; alu_src = 1'b0; alu_op = 2'b00;
    funct3 = 3'b000; funct7_5 = 1'b0; funct7_0 = 1'b0; forward_a = 2'b00; forward_b = 2'b00;
    em_alu_res = '0; wb_rd_out = '0;
    tick(); tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_alu_res", alu_res, 64'd0);
    chk("rst_pc_off", pc_off, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    chk("rst_ov", {63'd0, ov}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    // ADD 5+7, pc_off = 0x100 + (0x10<<1)
    issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 64'd5, 64'd7, 64'h10);
    chk("add_valid", {63'd0, out_valid}, 64'd1);
    chk("add_res", alu_res, 64'd12);
    chk("add_zero", {63'd0, zero}, 64'd0);
    chk("add_pc_off", pc_off, 64'h120);

    // SUB with EX/MEM forwarding on A
    forward_a = 2'b10; em_alu_res = 64'd100;
    issue(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 64'd3, 64'd1, 64'd0);
    forward_a = 2'b00;
    chk("fwd_sub_res", alu_res, 64'd99);

    // Signed add overflow
    issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    chk("ovf_res", alu_res, MIN64);
    chk("ovf_ov", {63'd0, ov}, 64'd1);

    // SUB 5-5 with WB forwarding on B -> zero
    forward_b = 2'b01; wb_rd_out = 64'd5;
    issue(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 64'd5, 64'd0, 64'd0);
    forward_b = 2'b00;
    chk("wbfwd_zero", {63'd0, zero}, 64'd1);
    chk("wbfwd_ov", {63'd0, ov}, 64'd0);

    // SRAI -64 >>> 4
    issue(2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFC0, 64'd0, 64'd4);
    chk("srai_res", alu_res, 64'hFFFF_FFFF_FFFF_FFFC);

    // Unsupported M-op funct3 -> 0 at latency 1
    issue(2'b10, 3'b001, 1'b0, 1'b1, 1'b0, 64'd9, 64'd3, 64'd0);
    funct7_0 = 1'b0;
    chk("mop_bad_valid", {63'd0, out_valid}, 64'd1);
    chk("mop_bad_res", alu_res, 64'd0);

    // DIV -7/2, pc_off = 0x1000 + (8<<1)
    pc_in = 64'h1000;
    md_op(3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, lat, rdy);
    chk("div_res", r, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_lat", 64'(lat), 64'd66);
    chk("div_rdy_low", {63'd0, rdy}, 64'd0);
    chk("div_pc_off", pc_off, 64'h1010);
    chk("div_ov", {63'd0, ov}, 64'd0);
    md_op(3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, r, lat, rdy);
    chk("rem_res", r, 64'hFFFF_FFFF_FFFF_FFFF);

    // Divide by zero and signed overflow
    md_op(3'b101, 64'd9, 64'd0, r, lat, rdy);
    chk("divu0_res", r, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("divu0_lat", 64'(lat), 64'd66);
    md_op(3'b111, 64'd9, 64'd0, r, lat, rdy);
    chk("remu0_res", r, 64'd9);
    md_op(3'b100, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, rdy);
    chk("divovf_res", r, MIN64);
    md_op(3'b110, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, rdy);
    chk("removf_res", r, 64'd0);
    chk("removf_zero", {63'd0, zero}, 64'd1);

    // Multiply
    md_op(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, lat, rdy);
    chk("mulhu_res", r, 64'd1);
    md_op(3'b000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, r, lat, rdy);
    chk("mul_res", r, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mul_lat", 64'(lat), 64'd66);

    // Flush mid-multiply
    issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 64'd3, 64'd5, 64'd0);
    funct7_0 = 1'b0;
    repeat (10) tick();
    chk("pre_flush_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    repeat (80) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_result", {63'd0, seen}, 64'd0);

    // Backpressure: result 42 held while a second op waits
    out_ready = 1'b0; pc_in = 64'h200;
    issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 64'd20, 64'd22, 64'd4);
    chk("bp_res", alu_res, 64'd42);
    held_res = alu_res;
    held_pc = pc_off;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 64'd1, 64'd1, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_res", alu_res, 64'd42);
      chk("bp_hold_pc", pc_off, 64'h208);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_res", alu_res, 64'd2);
    chk("bp_next_pc", pc_off, 64'h200);

    // Reset in the middle of a divide
    issue(2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 64'd100, 64'd7, 64'd0);
    funct7_0 = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_res", alu_res, 64'd0);
    chk("mrst_pc_off", pc_off, 64'd0);
    chk("mrst_zero", {63'd0, zero}, 64'd1);
    chk("mrst_ov", {63'd0, ov}, 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("mrst_no_result", {63'd0, seen}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
